// File: rtl/uart_fifo_pkg.sv
// Shared limits and flag bundle for the UART receive/transmit FIFO.
// The limits bound the legal WIDTH/SIZE_E combinations for every FIFO instance.
package uart_fifo_pkg;

    localparam int SIZE_E_MIN = 2;
    localparam int SIZE_E_MAX = 11;
    localparam int WIDTH_MAX  = 32;

    typedef struct packed {
        logic empty;
        logic full;
        logic trig;
        logic overflow;
    } fifo_flags_t;

    function automatic bit fifo_params_ok(input int width, input int size_e);
        return (width >= 1) && (width <= WIDTH_MAX) &&
               (size_e >= SIZE_E_MIN) && (size_e <= SIZE_E_MAX);
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage, WIDTH x 2**SIZE_E, sync write and enabled sync read.
// Read data appears one edge after rd_en; a same-address write in that edge returns the old word.
module uart_fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int SIZE_E = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_en,
    input  logic [SIZE_E-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_dat,
    input  logic              rd_en,
    input  logic [SIZE_E-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_dat
);

    localparam int DEPTH = 1 << SIZE_E;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_dat_q;

    // Storage is deliberately left unreset so large depths map onto block RAM.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_dat_q <= '0;
        end else if (rd_en) begin
            rd_dat_q <= mem_q[rd_addr];
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Synchronous FIFO with occupancy, trigger level, flush and sticky overflow; Q is valid one edge after READ.
// Writes into a full FIFO are dropped and flagged unless a read is accepted in the same edge; empty reads are ignored.
module uart_fifo_ctrl
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIZE_E = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLEAR,
    input  logic              WRITE,
    input  logic [WIDTH-1:0]  D,
    input  logic              READ,
    output logic [WIDTH-1:0]  Q,
    input  logic [SIZE_E:0]   TRIG_LVL,
    output logic [SIZE_E:0]   USAGE,
    output logic              EMPTY,
    output logic              FULL,
    output logic              TRIG,
    output logic              OVERFLOW
);

    if (!fifo_params_ok(WIDTH, SIZE_E)) begin : g_bad_params
        $error("uart_fifo_ctrl: WIDTH=%0d SIZE_E=%0d outside supported range", WIDTH, SIZE_E);
    end

    localparam logic [SIZE_E:0] DEPTH = {1'b1, {SIZE_E{1'b0}}};
    localparam logic [SIZE_E:0] ONE   = {{SIZE_E{1'b0}}, 1'b1};

    logic [SIZE_E:0] rd_ptr_q, rd_ptr_d;
    logic [SIZE_E:0] wr_ptr_q, wr_ptr_d;
    logic [SIZE_E:0] usage_q, usage_d;
    logic            ovf_q, ovf_d;
    logic            rd_acc, wr_acc, wr_drop;
    fifo_flags_t     flags;

    // All flags decode from registered state only; TRIG_LVL is the sole live input.
    always_comb begin
        flags.empty    = (usage_q == '0);
        flags.full     = (usage_q == DEPTH);
        flags.trig     = (TRIG_LVL != '0) && (usage_q >= TRIG_LVL);
        flags.overflow = ovf_q;
    end

    always_comb begin
        rd_acc   = READ && !flags.empty && !CLEAR;
        wr_acc   = WRITE && (!flags.full || rd_acc) && !CLEAR;
        wr_drop  = WRITE && !wr_acc && !CLEAR;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        usage_d  = usage_q;
        ovf_d    = ovf_q;
        if (CLEAR) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            usage_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + ONE;
            end
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + ONE;
            end
            usage_d = wr_ptr_d - rd_ptr_d;
            if (wr_drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            usage_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            usage_q  <= usage_d;
            ovf_q    <= ovf_d;
        end
    end

    uart_fifo_mem #(
        .WIDTH  (WIDTH),
        .SIZE_E (SIZE_E)
    ) u_mem (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[SIZE_E-1:0]),
        .wr_dat  (D),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q[SIZE_E-1:0]),
        .rd_dat  (Q)
    );

    assign USAGE    = usage_q;
    assign EMPTY    = flags.empty;
    assign FULL     = flags.full;
    assign TRIG     = flags.trig;
    assign OVERFLOW = flags.overflow;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl: a 4-deep and a 16-deep instance driven in lockstep,
// checked against a vector table and a queue-based reference model.
module tb_uart_fifo_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       clear = 1'b0, write = 1'b0, read = 1'b0;
    logic [7:0] d = 8'h00;
    logic [2:0] trig_lvl_a = 3'd0;
    logic [4:0] trig_lvl_b = 5'd0;

    logic [7:0] q_a, q_b;
    logic [2:0] usage_a;
    logic [4:0] usage_b;
    logic       empty_a, full_a, trig_a, ovf_a;
    logic       empty_b, full_b, trig_b, ovf_b;

    always #5 CLK = ~CLK;

    uart_fifo_ctrl #(.WIDTH(8), .SIZE_E(2)) dut_a (
        .CLK(CLK), .RST(RST), .CLEAR(clear), .WRITE(write), .D(d), .READ(read),
        .Q(q_a), .TRIG_LVL(trig_lvl_a), .USAGE(usage_a), .EMPTY(empty_a),
        .FULL(full_a), .TRIG(trig_a), .OVERFLOW(ovf_a)
    );

    uart_fifo_ctrl #(.WIDTH(8), .SIZE_E(4)) dut_b (
        .CLK(CLK), .RST(RST), .CLEAR(clear), .WRITE(write), .D(d), .READ(read),
        .Q(q_b), .TRIG_LVL(trig_lvl_b), .USAGE(usage_b), .EMPTY(empty_b),
        .FULL(full_b), .TRIG(trig_b), .OVERFLOW(ovf_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one queue per instance plus the last word read out.
    logic [7:0] mq [2][$];
    logic [7:0] m_q [2];
    bit         m_ovf [2];
    int         m_depth [2] = '{4, 16};

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            mq[u].delete();
            m_q[u]   = 8'h00;
            m_ovf[u] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int u = 0; u < 2; u++) begin
            bit rd_ok;
            bit wr_ok;
            if (clear) begin
                mq[u].delete();
                m_ovf[u] = 1'b0;
            end else begin
                rd_ok = read && (mq[u].size() > 0);
                wr_ok = write && ((mq[u].size() < m_depth[u]) || rd_ok);
                if (rd_ok) m_q[u] = mq[u].pop_front();
                if (wr_ok) mq[u].push_back(d);
                else if (write) m_ovf[u] = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        for (int u = 0; u < 2; u++) begin
            int    lvl;
            int    sz;
            string p;
            lvl = (u == 0) ? int'(trig_lvl_a) : int'(trig_lvl_b);
            sz  = mq[u].size();
            p   = $sformatf("%s/%s", tag, (u == 0) ? "a" : "b");
            chk({p, ".Q"},        (u == 0) ? int'(q_a)     : int'(q_b),     int'(m_q[u]));
            chk({p, ".USAGE"},    (u == 0) ? int'(usage_a) : int'(usage_b), sz);
            chk({p, ".EMPTY"},    (u == 0) ? int'(empty_a) : int'(empty_b), int'(sz == 0));
            chk({p, ".FULL"},     (u == 0) ? int'(full_a)  : int'(full_b),  int'(sz == m_depth[u]));
            chk({p, ".TRIG"},     (u == 0) ? int'(trig_a)  : int'(trig_b),  int'(lvl != 0 && sz >= lvl));
            chk({p, ".OVERFLOW"}, (u == 0) ? int'(ovf_a)   : int'(ovf_b),   int'(m_ovf[u]));
        end
    endtask

    task automatic step(input bit wr, input logic [7:0] dv, input bit rd, input bit clr,
                        input string tag);
        write = wr;
        d     = dv;
        read  = rd;
        clear = clr;
        model_edge();
        @(posedge CLK);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] d;
        bit         rd;
        bit         clr;
        logic [7:0] q;
        int         usage;
        bit         empty;
        bit         full;
        bit         trig;
        bit         ovf;
    } vec_t;

    vec_t tbl [21];

    initial begin
        logic [7:0] dat;
        int         wp;
        int         rp;

        // Expected values for the 4-deep instance with TRIG_LVL = 3.
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 3, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h33, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h33, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h33, 3, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 8'h04, 1'b0, 1'b0, 8'h33, 4, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 8'hBB, 1'b1, 1'b0, 8'h01, 4, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 8'hAA, 1'b0, 1'b0, 8'h01, 4, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 3, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 2, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hBB, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 8'h5C, 1'b1, 1'b0, 8'hBB, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h5C, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[19] = '{1'b1, 8'h77, 1'b0, 1'b1, 8'h5C, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h5C, 0, 1'b1, 1'b0, 1'b0, 1'b0};

        model_reset();
        #1 RST = 1'b1;
        #10;
        check_model("reset");
        @(negedge CLK);
        RST = 1'b0;

        // Directed table; the 16-deep instance runs the same stimulus with TRIG_LVL = 0.
        trig_lvl_a = 3'd3;
        trig_lvl_b = 5'd0;
        for (int i = 0; i < 21; i++) begin
            string t;
            t = $sformatf("tbl%0d", i);
            step(tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].clr, t);
            chk({t, ".Q"},        int'(q_a),     int'(tbl[i].q));
            chk({t, ".USAGE"},    int'(usage_a), tbl[i].usage);
            chk({t, ".EMPTY"},    int'(empty_a), int'(tbl[i].empty));
            chk({t, ".FULL"},     int'(full_a),  int'(tbl[i].full));
            chk({t, ".TRIG"},     int'(trig_a),  int'(tbl[i].trig));
            chk({t, ".OVERFLOW"}, int'(ovf_a),   int'(tbl[i].ovf));
        end

        // Trigger threshold of 14 on the 16-deep instance; 4-deep keeps TRIG_LVL = 0.
        trig_lvl_a = 3'd0;
        trig_lvl_b = 5'd14;
        for (int i = 0; i < 13; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, "trig_fill");
        chk("trig_at_13", int'(trig_b), 0);
        step(1'b1, 8'h4D, 1'b0, 1'b0, "trig_14th");
        chk("trig_at_14", int'(trig_b), 1);
        chk("trig_lvl0_full", int'(trig_a), 0);
        step(1'b0, 8'h00, 1'b1, 1'b0, "trig_read");
        chk("trig_after_read", int'(trig_b), 0);
        trig_lvl_b = 5'd0;
        step(1'b1, 8'h4E, 1'b0, 1'b0, "trig_off");
        chk("trig_lvl0_b", int'(trig_b), 0);
        step(1'b0, 8'h00, 1'b0, 1'b1, "trig_clear");

        // Three full fill/drain passes so both pointers wrap several times.
        dat = 8'h80;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 16; i++) begin
                step(1'b1, dat, 1'b0, 1'b0, "wrap_fill");
                dat++;
            end
            chk("wrap_full", int'(full_b), 1);
            for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");
            chk("wrap_empty", int'(empty_b), 1);
        end

        // Flush with a simultaneous write: the write must not land.
        for (int i = 0; i < 5; i++) step(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, "pre_clr");
        step(1'b1, 8'hE1, 1'b0, 1'b1, "clr_wr");
        chk("clr_wr_usage_b", int'(usage_b), 0);
        chk("clr_wr_ovf_a", int'(ovf_a), 0);
        step(1'b0, 8'h00, 1'b1, 1'b0, "clr_rd_empty");

        // Asynchronous reset mid-burst, sampled before the next rising edge.
        for (int i = 0; i < 3; i++) step(1'b1, 8'hF0 + 8'(i), 1'b1, 1'b0, "burst");
        step(1'b1, 8'hF3, 1'b0, 1'b0, "burst");
        step(1'b1, 8'hF4, 1'b1, 1'b0, "burst");
        RST = 1'b1;
        #2;
        model_reset();
        check_model("arst");
        write = 1'b0;
        read  = 1'b0;
        clear = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        step(1'b1, 8'h3C, 1'b0, 1'b0, "post_rst_wr");
        step(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_rd");

        // Randomised traffic with alternating fill/drain bias and varying thresholds.
        for (int i = 0; i < 3000; i++) begin
            int wp_bias;
            wp_bias = ((i / 150) % 2 == 0) ? 75 : 25;
            if (i % 97 == 0) begin
                trig_lvl_a = 3'($urandom_range(0, 7));
                trig_lvl_b = 5'($urandom_range(0, 31));
            end
            wp = int'($urandom_range(0, 99));
            rp = int'($urandom_range(0, 99));
            step(wp < wp_bias, 8'($urandom), rp >= wp_bias,
                 $urandom_range(0, 199) == 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
